// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier.
// One Booth step per clock. The result is the low WIDTH bits of the signed
// product, with a flag for when that truncation loses significance.
module mult_booth_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   // The upper half carries one extra sign bit, so that negating the most
   // negative multiplicand is exact.
   logic [WIDTH:0]     mcand;
   logic [WIDTH:0]     upper;
   logic [WIDTH-1:0]   lower;
   logic               extra;
   logic [CW-1:0]      count;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     upper_sh;
   logic [WIDTH-1:0]   lower_sh;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     hi_bits;
   logic               last_step;
   logic               ovf;

   assign last_step = (count == CW'(WIDTH - 1));

   // One Booth step: add/subtract on the upper half, then arithmetic shift right of {upper, lower, extra}
   always_comb begin
      sum = upper;
      case ({lower[0], extra})
         2'b10:   sum = upper - mcand;
         2'b01:   sum = upper + mcand;
         default: sum = upper;
      endcase
      upper_sh = {sum[WIDTH], sum[WIDTH:1]};
      lower_sh = {sum[0], lower[WIDTH-1:1]};
   end

   // Product as it stands after the current step; it is only used after the last step
   assign product = {upper_sh[WIDTH-1:0], lower_sh};
   assign hi_bits = product[2*WIDTH-1:WIDTH-1];
   assign ovf     = !((&hi_bits) || (~|hi_bits));

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next state. A start pulse restarts the multiply from any state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (ctrl_MULT) state_next = RUN;
         RUN: begin
            if (ctrl_MULT)      state_next = RUN;
            else if (last_step) state_next = DONE;
         end
         DONE: state_next = ctrl_MULT ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands on start, step in RUN, register the result on the final step
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcand          <= '0;
         upper          <= '0;
         lower          <= '0;
         extra          <= 1'b0;
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_MULT) begin
         mcand <= {data_operandA[WIDTH-1], data_operandA};
         upper <= '0;
         lower <= data_operandB;
         extra <= 1'b0;
         count <= '0;
      end else if (state == RUN) begin
         upper <= upper_sh;
         lower <= lower_sh;
         extra <= lower[0];
         count <= count + CW'(1);
         if (last_step) begin
            data_result    <= product[WIDTH-1:0];
            data_exception <= ovf;
         end
      end
   end

   assign data_resultRDY = (state == DONE);
   assign busy           = (state == RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Bench for mult_booth_seq: vector table, result scoreboard, reset and abort sequences.
module tb_mult_booth_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   mult_booth_seq #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        exc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Reference: full 64-bit signed product, low word and truncation flag
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc);
      longint      p;
      logic [63:0] pu;
      logic [32:0] hi;
      p   = longint'($signed(a)) * longint'($signed(b));
      pu  = p;
      hi  = pu[63:31];
      res = pu[31:0];
      exc = !((&hi) || (~|hi));
   endtask

   // Scoreboard: every result strobe must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (reset === 1'b1 && data_resultRDY === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rdy: got result %h with no multiply outstanding", data_result);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", data_result, mon_e.res);
            check("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
            $display("[TB] result %h exception %0b", data_result, data_exception);
         end
      end
   end

   task automatic pulse(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      data_operandA = $urandom();
      data_operandB = $urandom();
   endtask

   // Follows one multiply from its start edge: latency, strobe width, busy span, result stability
   task automatic wait_done(input string nm, input logic [31:0] prev);
      int rdy_k  = -1;
      int rdy_n  = 0;
      int busy_n = 0;
      int stable = 1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clock);
         if (busy === 1'b1) busy_n++;
         if (data_resultRDY === 1'b1) begin
            rdy_n++;
            if (rdy_k < 0) rdy_k = k;
         end
         if (k < 32 && data_result !== prev) stable = 0;
      end
      check({nm, "_latency"}, rdy_k, 32);
      check({nm, "_rdy_count"}, rdy_n, 1);
      check({nm, "_busy_cycles"}, busy_n, 32);
      check({nm, "_result_stable"}, stable, 1);
   endtask

   initial begin
      logic [31:0] prev;
      exp_t        e;
      int          rdy_n;

      vecs[0] = '{32'd7,        32'd6,        32'd42,       1'b0};
      vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
      vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      vecs[4] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
      vecs[5] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
      vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
      vecs[7] = '{32'd0,        32'h12345678, 32'h00000000, 1'b0};
      for (int i = 8; i < 12; i++) begin
         vecs[i].a = $urandom();
         vecs[i].b = (i % 2 == 0) ? 32'($urandom_range(0, 65535)) : $urandom();
         model(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
      end

      // Reset state
      #12;
      check("reset_result", data_result, 32'h0);
      check("reset_exception", {31'b0, data_exception}, 32'h0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // Table-driven multiplies
      for (int i = 0; i < 12; i++) begin
         e.res = vecs[i].res;
         e.exc = vecs[i].exc;
         exp_q.push_back(e);
         prev = data_result;
         $display("[TB] vec %0d: %h * %h", i, vecs[i].a, vecs[i].b);
         pulse(vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i), prev);
      end

      // Reset in the middle of a multiply
      $display("[TB] reset during 100*100");
      pulse(32'd100, 32'd100);
      repeat (10) @(negedge clock);
      check("run_busy_before_reset", {31'b0, busy}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_result", data_result, 32'h0);
      check("async_reset_exception", {31'b0, data_exception}, 32'h0);
      check("async_reset_rdy", {31'b0, data_resultRDY}, 32'h0);
      check("async_reset_busy", {31'b0, busy}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      rdy_n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_n++;
      end
      check("post_reset_quiet", rdy_n, 0);

      // Abort-and-restart: 9*9 replaced by 2*3 mid-run
      $display("[TB] abort 9*9 with 2*3");
      e.res = 32'd6;
      e.exc = 1'b0;
      exp_q.push_back(e);
      prev = data_result;
      pulse(32'd9, 32'd9);
      repeat (14) @(negedge clock);
      check("abort_busy", {31'b0, busy}, 32'h1);
      pulse(32'd2, 32'd3);
      wait_done("abort", prev);

      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_booth_seq.md
MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ctrl_MULT, input, 1, start pulse; operands captured on the edge where it is sampled high.
REQ-005 SHALL have port data_operandA, input, WIDTH, signed multiplicand.
REQ-006 SHALL have port data_operandB, input, WIDTH, signed multiplier.
REQ-007 SHALL have port data_result, output, WIDTH, low WIDTH bits of the signed product.
REQ-008 SHALL have port data_exception, output, 1, signed overflow flag for data_result.
REQ-009 SHALL have port data_resultRDY, output, 1, one-cycle result-valid strobe.
REQ-010 SHALL have port busy, output, 1, high while a multiply is in progress.

Function
REQ-011 SHALL implement three states: IDLE, RUN and DONE.
REQ-012 SHALL, on an edge with ctrl_MULT=1 in any state, latch both operands, clear the step counter, clear the upper product half, clear the Booth extra bit, and enter RUN.
REQ-013 SHALL perform one radix-2 Booth step per RUN cycle: inspect {multiplier LSB, extra bit}; 10 -> subtract multiplicand from upper half; 01 -> add multiplicand to upper half; 00/11 -> no operation; then arithmetic-shift the whole {upper, lower, extra} register right by 1.
REQ-014 SHALL hold the upper product half at WIDTH+1 bits (sign-extended multiplicand) so that negating -2^(WIDTH-1) is exact.
REQ-015 SHALL leave RUN for DONE on the edge that completes step WIDTH; with WIDTH=32, data_resultRDY is high in the cycle following the 32nd edge after the start edge.
REQ-016 SHALL, on entering DONE, load data_result with product[WIDTH-1:0] and set data_exception=1 iff product[2*WIDTH-1:WIDTH-1] is not all zeros and not all ones.
REQ-017 SHALL assert data_resultRDY only in DONE, for exactly one cycle per completed multiply.
REQ-018 SHALL move DONE -> IDLE on the next edge unless ctrl_MULT=1, which restarts per REQ-012.
REQ-019 SHALL hold data_result and data_exception stable from DONE until the next DONE or reset; both SHALL NOT change during RUN.
REQ-020 SHALL assert busy=1 in RUN only.
REQ-021 SHALL treat ctrl_MULT=1 during RUN as abort-and-restart: the in-flight multiply produces no data_resultRDY; the new one completes per REQ-015 counted from the restart edge.
REQ-022 SHALL ignore operand changes except on ctrl_MULT edges.
REQ-023 SHALL perform all additions and subtractions modulo 2^(WIDTH+1), with no dependence on carry-out.

Reset
REQ-024 SHALL, while reset=0, immediately force IDLE, data_result=0, data_exception=0, data_resultRDY=0 and busy=0, independent of clock.
REQ-025 SHALL discard any in-flight multiply on reset; no data_resultRDY occurs after release until a new ctrl_MULT.
REQ-026 SHALL sample ctrl_MULT normally on the first rising edge after reset deasserts.

Verification
REQ-027 SHALL cover: A=7, B=6, pulse -> data_resultRDY high exactly 32 edges later for one cycle, result=42, exception=0, busy high for 32 cycles.
REQ-028 SHALL cover: A=-3, B=5 -> result=0xFFFFFFF1, exception=0.
REQ-029 SHALL cover: A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1.
REQ-030 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1; and A=0x80000000, B=1 -> result=0x80000000, exception=0.
REQ-031 SHALL cover: start 100*100, assert reset at RUN cycle 10 -> all outputs 0 at once; after release no data_resultRDY within 40 cycles.
REQ-032 SHALL cover: start 9*9, re-pulse with 2*3 at RUN cycle 15 -> single data_resultRDY 32 edges after the second pulse, result=6.
